bist_fail_logger: RTL and testbench

- Response-analysis stage directly downstream of the memory BIST controller; consumes its compare strobe, read address, expected pattern and memory read data.
- Flags each mismatch, counts failures and logs the first LOG_DEPTH failing addresses plus XOR syndromes into a small FIFO.
- The diagnostic host drains the FIFO over a valid/pop handshake and reads a final pass/fail verdict once BIST completes.

---
 rtl/bist_pkg.sv | 18 +
 rtl/bist_fail_logger_if.sv | 38 +++
 rtl/bist_log_fifo.sv | 58 +++++
 rtl/bist_fail_logger.sv | 148 ++++++++++++++
 tb/tb_bist_fail_logger.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Purpose: shared types and constants for the BIST failure logger slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bist_pkg;

    localparam int unsigned BIST_ADDR_W = 5;
    localparam int unsigned BIST_DATA_W = 8;

    // One log entry is {address, syndrome}.
    localparam int unsigned LOG_ENTRY_W = BIST_ADDR_W + BIST_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/bist_fail_logger_if.sv
// Purpose: bundle of the BIST-controller side and diagnostic-host side signals.
// Latency: n/a (wiring only).
// Backpressure: host drains via log_valid/log_pop; the compare stream has none.
// Ports: master = controller + host (drives compares, clr, pops); slave = logger.
interface bist_fail_logger_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              clr;
    logic              cmp_en;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] mem_data;
    logic              bist_done;
    logic              log_pop;
    logic              cmp_out;
    logic [CNT_W-1:0]  err_count;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_syndrome;
    logic              log_full;
    logic              log_overflow;
    logic              result_valid;
    logic              pass;

    modport master (
        output clr, cmp_en, cmp_addr, exp_data, mem_data, bist_done, log_pop,
        input  cmp_out, err_count, log_valid, log_addr, log_syndrome,
               log_full, log_overflow, result_valid, pass
    );

    modport slave (
        input  clr, cmp_en, cmp_addr, exp_data, mem_data, bist_done, log_pop,
        output cmp_out, err_count, log_valid, log_addr, log_syndrome,
               log_full, log_overflow, result_valid, pass
    );
endinterface

// File: rtl/bist_log_fifo.sv
// Purpose: circular-buffer FIFO holding failure-log entries; head shown combinationally.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push while full (without a pop) is dropped; pop while empty is ignored.
// Ports: clk/reset, clr_i sync clear, push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o.
module bist_log_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_dat_o = mem_q[rd_ptr_q[PW-1:0]];

    // A pop on a full FIFO frees the slot the same cycle, so the push may land.
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
            end
        end
    end
endmodule

// File: rtl/bist_fail_logger.sv
// Purpose: BIST response analyser - flags mismatches, counts them, logs first failures.
// Latency: 1 cycle from compare strobe to cmp_out/err_count/log update.
// Backpressure: none on compares; full log drops entries and sets sticky log_overflow.
// Ports: clk, reset (async, active-high), bus (slave modport of bist_fail_logger_if).
// Option: define BIST_FAIL_DEDUP_EN to suppress logging a repeat of the last pushed address.
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W    = BIST_ADDR_W,
    parameter int unsigned DATA_W    = BIST_DATA_W,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bist_fail_logger_if.slave    bus
);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               cmp_out_q, cmp_out_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               ovf_q, ovf_d;
    logic               cmp_take;
    logic               mismatch;
    logic               dup;
    logic               push_req;
    logic               push_ok;
    logic [DATA_W-1:0]  syndrome;
    logic [ENTRY_W-1:0] head_dat;
    logic               fifo_full;
    logic               fifo_empty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (bus.clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // bist_done wins: a run with no compares goes straight to DONE.
                if (bus.bist_done)   state_d = ST_DONE;
                else if (bus.cmp_en) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: if (bus.bist_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmp_take         = bus.cmp_en && (state_q != ST_DONE);
        bus.result_valid = (state_q == ST_DONE);
        bus.pass         = (state_q == ST_DONE) && (err_cnt_q == '0);
    end

    // ---------------- comparator / dedup / counters ----------------
    assign syndrome = bus.exp_data ^ bus.mem_data;
    assign mismatch = cmp_take && (syndrome != '0);

`ifdef BIST_FAIL_DEDUP_EN
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_vld_q;

    // Valid bit keeps address 0 from matching a cleared register.
    assign dup = last_vld_q && (last_addr_q == bus.cmp_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (bus.clr) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (push_ok) begin
            last_addr_q <= bus.cmp_addr;
            last_vld_q  <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign push_req = mismatch && !dup;
    // Mirrors the FIFO acceptance rule: room, or a pop freeing a slot this cycle.
    assign push_ok  = push_req && (!fifo_full || bus.log_pop);

    always_comb begin
        cmp_out_d = mismatch;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
        ovf_d = ovf_q || (push_req && !push_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_out_q <= 1'b0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else if (bus.clr) begin
            cmp_out_q <= 1'b0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cmp_out_q <= cmp_out_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // ---------------- failure log ----------------
    bist_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (bus.clr),
        .push_i     (push_req),
        .push_dat_i ({bus.cmp_addr, syndrome}),
        .pop_i      (bus.log_pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.cmp_out      = cmp_out_q;
    assign bus.err_count    = err_cnt_q;
    assign bus.log_overflow = ovf_q;
    assign bus.log_full     = fifo_full;
    assign bus.log_valid    = !fifo_empty;
    // Head fields read as zero when empty so stale storage never leaks out after clr.
    assign bus.log_addr     = fifo_empty ? '0 : head_dat[ENTRY_W-1:DATA_W];
    assign bus.log_syndrome = fifo_empty ? '0 : head_dat[DATA_W-1:0];
endmodule

// File: tb/tb_bist_fail_logger.sv
// Purpose: directed self-checking bench for bist_fail_logger.
// Latency: n/a.
// Backpressure: n/a.
module tb_bist_fail_logger;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   entries;

    bist_fail_logger_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(8)) bus ();

    bist_fail_logger #(
        .ADDR_W    (5),
        .DATA_W    (8),
        .LOG_DEPTH (4),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input logic [4:0] a, input logic [7:0] e, input logic [7:0] m);
        bus.cmp_en   = 1'b1;
        bus.cmp_addr = a;
        bus.exp_data = e;
        bus.mem_data = m;
        tick();
        bus.cmp_en   = 1'b0;
    endtask

    task automatic pop();
        bus.log_pop = 1'b1;
        tick();
        bus.log_pop = 1'b0;
    endtask

    task automatic done_pulse();
        bus.bist_done = 1'b1;
        tick();
        bus.bist_done = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.clr = 1'b0; bus.cmp_en = 1'b0; bus.cmp_addr = '0; bus.exp_data = '0;
        bus.mem_data = '0; bus.bist_done = 1'b0; bus.log_pop = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cmp_out",  32'(bus.cmp_out), 32'd0);
        check("rst_err",      32'(bus.err_count), 32'd0);
        check("rst_valid",    32'(bus.log_valid), 32'd0);
        check("rst_full",     32'(bus.log_full), 32'd0);
        check("rst_ovf",      32'(bus.log_overflow), 32'd0);
        check("rst_result",   32'(bus.result_valid), 32'd0);
        check("rst_pass",     32'(bus.pass), 32'd0);

        // All-match run
        for (int i = 0; i < 32; i++) cmp(5'(i), 8'h55, 8'h55);
        check("match_cmp_out", 32'(bus.cmp_out), 32'd0);
        done_pulse();
        tick();
        check("match_err",    32'(bus.err_count), 32'd0);
        check("match_valid",  32'(bus.log_valid), 32'd0);
        check("match_result", 32'(bus.result_valid), 32'd1);
        check("match_pass",   32'(bus.pass), 32'd1);
        // Compares in DONE are ignored
        cmp(5'd3, 8'h00, 8'hFF);
        check("done_ign_cmp", 32'(bus.cmp_out), 32'd0);
        check("done_ign_err", 32'(bus.err_count), 32'd0);
        check("done_ign_log", 32'(bus.log_valid), 32'd0);

        // clr returns to IDLE
        do_clr();
        check("clr_result", 32'(bus.result_valid), 32'd0);
        check("clr_pass",   32'(bus.pass), 32'd0);

        // Single fault
        cmp(5'd9, 8'hAA, 8'hA8);
        check("sf_cmp_out", 32'(bus.cmp_out), 32'd1);
        check("sf_addr",    32'(bus.log_addr), 32'd9);
        check("sf_syn",     32'(bus.log_syndrome), 32'h02);
        check("sf_err",     32'(bus.err_count), 32'd1);
        tick();
        check("sf_cmp_out_low", 32'(bus.cmp_out), 32'd0);
        done_pulse();
        check("sf_result", 32'(bus.result_valid), 32'd1);
        check("sf_pass",   32'(bus.pass), 32'd0);
        pop();
        check("sf_drain_in_done", 32'(bus.log_valid), 32'd0);

        // Overflow
        do_clr();
        for (int i = 0; i < 6; i++) cmp(5'(i), 8'hFF, 8'h00);
        check("ov_full", 32'(bus.log_full), 32'd1);
        check("ov_ovf",  32'(bus.log_overflow), 32'd1);
        check("ov_err",  32'(bus.err_count), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check("ov_pop_valid", 32'(bus.log_valid), 32'd1);
            check("ov_pop_addr",  32'(bus.log_addr), 32'(i));
            pop();
        end
        check("ov_empty",  32'(bus.log_valid), 32'd0);
        check("ov_sticky", 32'(bus.log_overflow), 32'd1);
        pop();
        check("ov_pop_empty_ign", 32'(bus.log_valid), 32'd0);

        // Push and pop together when full
        do_clr();
        check("clr_ovf", 32'(bus.log_overflow), 32'd0);
        for (int i = 0; i < 4; i++) cmp(5'(i), 8'h0F, 8'h00);
        check("pp_full_before", 32'(bus.log_full), 32'd1);
        bus.log_pop = 1'b1;
        cmp(5'd20, 8'hFF, 8'h00);
        bus.log_pop = 1'b0;
        check("pp_full_after", 32'(bus.log_full), 32'd1);
        check("pp_ovf",        32'(bus.log_overflow), 32'd0);
        check("pp_err",        32'(bus.err_count), 32'd5);
        check("pp_head",       32'(bus.log_addr), 32'd1);
        pop(); pop(); pop();
        check("pp_tail_addr", 32'(bus.log_addr), 32'd20);
        check("pp_tail_syn",  32'(bus.log_syndrome), 32'hFF);
        pop();
        check("pp_empty", 32'(bus.log_valid), 32'd0);

        // Push and pop together when empty: push lands
        bus.log_pop = 1'b1;
        cmp(5'd11, 8'h01, 8'h00);
        bus.log_pop = 1'b0;
        check("pe_valid", 32'(bus.log_valid), 32'd1);
        check("pe_addr",  32'(bus.log_addr), 32'd11);

        // Mid-run asynchronous reset
        do_clr();
        cmp(5'd1, 8'h11, 8'h10);
        cmp(5'd2, 8'h11, 8'h10);
        cmp(5'd3, 8'h11, 8'h10);
        check("mr_err_pre", 32'(bus.err_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("mr_err",     32'(bus.err_count), 32'd0);
        check("mr_cmp_out", 32'(bus.cmp_out), 32'd0);
        check("mr_valid",   32'(bus.log_valid), 32'd0);
        check("mr_addr",    32'(bus.log_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        cmp(5'd4, 8'h80, 8'h00);
        check("mr_new_err",   32'(bus.err_count), 32'd1);
        check("mr_new_valid", 32'(bus.log_valid), 32'd1);

        // Consecutive mismatches at the same address
        do_clr();
        cmp(5'd7, 8'h3C, 8'h00);
        cmp(5'd7, 8'h3C, 8'h00);
        check("dd_err", 32'(bus.err_count), 32'd2);
        entries = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.log_valid) begin
                entries++;
                pop();
            end
        end
`ifdef BIST_FAIL_DEDUP_EN
        check("dd_entries", 32'(entries), 32'd1);
`else
        check("dd_entries", 32'(entries), 32'd2);
`endif
        check("dd_ovf", 32'(bus.log_overflow), 32'd0);

        // Counter saturation
        do_clr();
        for (int i = 0; i < 260; i++) cmp(5'(i), 8'h01, 8'h02);
        check("sat_err", 32'(bus.err_count), 32'd255);
        check("sat_ovf", 32'(bus.log_overflow), 32'd1);

        // bist_done in IDLE with no compares
        do_clr();
        done_pulse();
        check("idle_done_result", 32'(bus.result_valid), 32'd1);
        check("idle_done_pass",   32'(bus.pass), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
